mac_dot_acc: RTL

//   Parametrised signed multi-lane multiply-accumulate engine for the NN datapath.

---
 rtl/mac_dot_acc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mac_dot_acc.sv
// rtl/mac_dot_acc.sv - signed multi-lane multiply-accumulate dot-product engine
// Optional clamp-on-overflow accumulation is enabled by defining MAC_SAT_EN.
module mac_dot_acc #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*IN_W-1:0]   in_a,
    input  logic [LANES*IN_W-1:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);

    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    // Extended width holds any acc + SUM exactly, even if ACC_W < SUM_W.
    localparam int EW     = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    logic adv;
    logic s2_load;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [SUM_W-1:0]  lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]  = PROD_W'($signed(in_a[i*IN_W +: IN_W])) *
                       PROD_W'($signed(in_b[i*IN_W +: IN_W]));
            lane_sum = lane_sum + SUM_W'(prod[i]);
        end
    end

    logic signed [SUM_W-1:0] s1_sum;
    logic                    s1_valid;
    logic                    s1_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= lane_sum;
                s1_last <= in_last;
            end
        end
    end

    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic                    ovf_acc;

    logic signed [EW-1:0]    base_w;
    logic signed [EW-1:0]    add_w;
    logic signed [EW-1:0]    nxt_w;
    logic signed [ACC_W-1:0] nxt_trunc;
    logic                    ovf;
    logic                    ovf_next;
    logic signed [ACC_W-1:0] acc_next;

    assign s2_load = adv && s1_valid;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic sat_pos;
    logic sat_neg;
    logic sat_pos_next;
    logic sat_neg_next;
`endif

    always_comb begin
        base_w    = first ? '0 : EW'(acc);
        add_w     = EW'(s1_sum);
        nxt_w     = base_w + add_w;
        nxt_trunc = nxt_w[ACC_W-1:0];
        ovf       = (EW'(nxt_trunc) != nxt_w);
        ovf_next  = (first ? 1'b0 : ovf_acc) | ovf;
`ifdef MAC_SAT_EN
        // Once clamped, the vector stays pinned in that direction.
        sat_pos_next = first ? (ovf && !nxt_w[EW-1])
                             : (sat_pos || (!sat_neg && ovf && !nxt_w[EW-1]));
        sat_neg_next = first ? (ovf && nxt_w[EW-1])
                             : (sat_neg || (!sat_pos && ovf && nxt_w[EW-1]));
        if (sat_pos_next) begin
            acc_next = ACC_MAX;
        end else if (sat_neg_next) begin
            acc_next = ACC_MIN;
        end else begin
            acc_next = nxt_trunc;
        end
`else
        acc_next = nxt_trunc;
`endif
    end

`ifdef MAC_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_pos <= 1'b0;
            sat_neg <= 1'b0;
        end else if (s2_load) begin
            sat_pos <= s1_last ? 1'b0 : sat_pos_next;
            sat_neg <= s1_last ? 1'b0 : sat_neg_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            first     <= 1'b1;
            ovf_acc   <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                if (s1_last) begin
                    out_data <= acc_next;
                    out_ovf  <= ovf_next;
                    acc      <= '0;
                    first    <= 1'b1;
                    ovf_acc  <= 1'b0;
                end else begin
                    acc      <= acc_next;
                    first    <= 1'b0;
                    ovf_acc  <= ovf_next;
                end
            end
            if (s2_load && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
